// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480 timing constants and rgb332 colour helpers
package vga_pkg;

  localparam int HBP  = 144;
  localparam int VBP  = 31;
  localparam int HACT = 640;
  localparam int VACT = 480;

  typedef logic [7:0] rgb332_t;

  function automatic logic [2:0] rgb_red(input rgb332_t c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb_green(input rgb332_t c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb_blue(input rgb332_t c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/vga_axis_mover.sv
// rtl/vga_axis_mover.sv - one axis of box motion: position, direction, edge clamp and flip
module vga_axis_mover #(
  parameter int LIMIT = 640,
  parameter int BOX   = 32,
  parameter int STEP  = 4,
  parameter int P0    = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       move,
  output logic [9:0] pos,
  output logic       hit
);

  // Far edge the box's leading side may reach; all arithmetic is 11 bits so
  // pos+STEP can never wrap back into range.
  localparam logic [10:0] HI     = 11'(LIMIT - BOX);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic       dir;        // 1 = increasing, 0 = decreasing
  logic [10:0] pos_w;
  logic [9:0]  next_pos;
  logic        next_dir;

  // Next position/direction if a move happens now; hit reports an edge landing
  always_comb begin
    pos_w    = {1'b0, pos};
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir) begin
      if (pos_w + STEP11 >= HI) begin
        next_pos = HI[9:0];
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = 10'(pos_w + STEP11);
      end
    end else begin
      if (pos_w <= STEP11) begin
        next_pos = 10'd0;
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = 10'(pos_w - STEP11);
      end
    end
  end

  // Position and direction only change on a move event
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pos <= 10'(P0);
      dir <= 1'b1;
    end else if (move) begin
      pos <= next_pos;
      dir <= next_dir;
    end
  end

endmodule

// File: rtl/vga_bounce_box.sv
// rtl/vga_bounce_box.sv - bouncing square pixel generator behind the 640x480 timing generator
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int          HBP        = vga_pkg::HBP,
  parameter int          VBP        = vga_pkg::VBP,
  parameter int          HACT       = vga_pkg::HACT,
  parameter int          VACT       = vga_pkg::VACT,
  parameter int          BOX        = 32,
  parameter int          STEP       = 4,
  parameter int          SPEED_DIV  = 1,
  parameter int          X0         = 304,
  parameter int          Y0         = 224,
  parameter logic [7:0]  BG_COLOR   = 8'h02,
  parameter logic [7:0]  COLOR0     = 8'hE0,
  parameter logic [7:0]  COLOR_STEP = 8'h25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       vidon,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       bounce
);

  localparam logic [7:0]  FC_LAST = 8'(SPEED_DIV - 1);
  localparam logic [10:0] BOX11   = 11'(BOX);

  logic        vsync_d;
  logic        tick;
  logic        move;
  logic [7:0]  fc;
  rgb332_t     color;
  logic [9:0]  x, y;
  logic        hit_x, hit_y;
  logic [9:0]  px, py;
  logic        inbox;
  rgb332_t     pix;

  // A frame tick is the falling edge of vsync, i.e. inside vertical blanking
  assign tick = vsync_d & ~vsync;
  assign move = tick & run & (fc == FC_LAST);

  vga_axis_mover #(
    .LIMIT (HACT),
    .BOX   (BOX),
    .STEP  (STEP),
    .P0    (X0)
  ) u_x (
    .clk  (clk),
    .clr  (clr),
    .move (move),
    .pos  (x),
    .hit  (hit_x)
  );

  vga_axis_mover #(
    .LIMIT (VACT),
    .BOX   (BOX),
    .STEP  (STEP),
    .P0    (Y0)
  ) u_y (
    .clk  (clk),
    .clr  (clr),
    .move (move),
    .pos  (y),
    .hit  (hit_y)
  );

  // vsync history for edge detection and the frames-per-move divider
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vsync_d <= 1'b1;
      fc      <= 8'd0;
    end else begin
      vsync_d <= vsync;
      if (tick && run) begin
        fc <= (fc == FC_LAST) ? 8'd0 : fc + 8'd1;
      end
    end
  end

  // Colour steps once per bouncing move, even when both axes hit together
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      color  <= COLOR0;
      bounce <= 1'b0;
    end else begin
      bounce <= move & (hit_x | hit_y);
      if (move && (hit_x || hit_y)) begin
        color <= color + COLOR_STEP;
      end
    end
  end

  // Box membership of the current pixel in active-area coordinates
  always_comb begin
    px    = hc - 10'(HBP);
    py    = vc - 10'(VBP);
    inbox = ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < {1'b0, x} + BOX11) &&
            ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} < {1'b0, y} + BOX11);
    if (!vidon) begin
      pix = 8'h00;
    end else if (inbox) begin
      pix = color;
    end else begin
      pix = BG_COLOR;
    end
  end

  // Registered colour and syncs share one clock of latency
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      red     <= 3'd0;
      green   <= 3'd0;
      blue    <= 2'd0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      red     <= rgb_red(pix);
      green   <= rgb_green(pix);
      blue    <= rgb_blue(pix);
      hsync_o <= hsync;
      vsync_o <= vsync;
    end
  end

endmodule

// File: tb/tb_vga_bounce_box.sv
// tb/tb_vga_bounce_box.sv - scoreboard bench for vga_bounce_box (default and divided/corner instances)
module tb_vga_bounce_box;

  localparam int HB = 144;
  localparam int VB = 31;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       run = 1'b1;
  logic       vidon = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;

  logic [2:0] red_a, green_a, red_b, green_b;
  logic [1:0] blue_a, blue_b;
  logic       hso_a, vso_a, bnc_a, hso_b, vso_b, bnc_b;

  always #20 clk = ~clk;

  vga_bounce_box dut_a (
    .clk(clk), .clr(clr), .run(run), .vidon(vidon), .hsync(hsync), .vsync(vsync),
    .hc(hc), .vc(vc), .red(red_a), .green(green_a), .blue(blue_a),
    .hsync_o(hso_a), .vsync_o(vso_a), .bounce(bnc_a)
  );

  vga_bounce_box #(.SPEED_DIV(3), .X0(604), .Y0(444)) dut_b (
    .clk(clk), .clr(clr), .run(run), .vidon(vidon), .hsync(hsync), .vsync(vsync),
    .hc(hc), .vc(vc), .red(red_b), .green(green_b), .blue(blue_b),
    .hsync_o(hso_b), .vsync_o(vso_b), .bounce(bnc_b)
  );

  typedef struct {
    logic [7:0] rgb_a;
    logic [7:0] rgb_b;
    logic       hs;
    logic       vs;
    logic       ba;
    logic       bb;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int         mx[2], my[2], mdx[2], mdy[2], mfc[2], mdiv[2];
  logic [7:0] mcol[2];
  bit         mvs_d;
  bit         hs_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mx[0] = 304; my[0] = 224; mdiv[0] = 1;
    mx[1] = 604; my[1] = 444; mdiv[1] = 3;
    for (int i = 0; i < 2; i++) begin
      mdx[i] = 1; mdy[i] = 1; mfc[i] = 0; mcol[i] = 8'hE0;
    end
    mvs_d = 1'b1;
  endtask

  task automatic axis(inout int p, inout int d, input int lim, output bit hit);
    hit = 1'b0;
    if (d > 0) begin
      if (p + 4 >= lim - 32) begin p = lim - 32; d = -1; hit = 1'b1; end
      else p = p + 4;
    end else begin
      if (p <= 4) begin p = 0; d = 1; hit = 1'b1; end
      else p = p - 4;
    end
  endtask

  function automatic logic [7:0] exp_pix(input int i, input int h, input int v, input bit vo);
    int px, py;
    px = (h - HB) & 1023;
    py = (v - VB) & 1023;
    if (!vo) return 8'h00;
    if (px >= mx[i] && px < mx[i] + 32 && py >= my[i] && py < my[i] + 32) return mcol[i];
    return 8'h02;
  endfunction

  task automatic pop_compare();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rgb_a",   {red_a, green_a, blue_a}, e.rgb_a);
      check("rgb_b",   {red_b, green_b, blue_b}, e.rgb_b);
      check("hsync_o", hso_a, e.hs);
      check("vsync_o", vso_a, e.vs);
      check("bounce_a", bnc_a, e.ba);
      check("bounce_b", bnc_b, e.bb);
    end
  endtask

  // one clock: compare last cycle's outputs, drive new inputs, predict next outputs
  task automatic cyc(input int h, input int v, input bit vo, input bit hs, input bit vs);
    exp_t e;
    bit hx, hy, tk;
    @(negedge clk);
    pop_compare();
    hc = 10'(h); vc = 10'(v); vidon = vo; hsync = hs; vsync = vs;
    e.rgb_a = exp_pix(0, h, v, vo);
    e.rgb_b = exp_pix(1, h, v, vo);
    e.hs = hs; e.vs = vs; e.ba = 1'b0; e.bb = 1'b0;
    tk = mvs_d && !vs;
    mvs_d = vs;
    if (tk && run) begin
      for (int i = 0; i < 2; i++) begin
        if (mfc[i] == mdiv[i] - 1) begin
          mfc[i] = 0;
          axis(mx[i], mdx[i], 640, hx);
          axis(my[i], mdy[i], 480, hy);
          if (hx || hy) begin
            mcol[i] = mcol[i] + 8'h25;
            if (i == 0) e.ba = 1'b1; else e.bb = 1'b1;
          end
        end else begin
          mfc[i] = mfc[i] + 1;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pop_compare();
    q.delete();
    #5 clr = 1'b0;
    #1;
    check("rst_rgb_a", {red_a, green_a, blue_a}, 8'h00);
    check("rst_rgb_b", {red_b, green_b, blue_b}, 8'h00);
    check("rst_hsync_o", hso_a, 1'b1);
    check("rst_vsync_o", vso_b, 1'b1);
    check("rst_bounce", {bnc_a, bnc_b}, 2'b00);
    model_reset();
    hc = '0; vc = '0; vidon = 1'b0; hsync = 1'b1; vsync = 1'b1;
    #2 clr = 1'b1;
  endtask

  task automatic probe(input int i);
    int x, y;
    x = mx[i]; y = my[i];
    hs_t = ~hs_t; cyc(HB + x, VB + y, 1'b1, hs_t, 1'b1);
    hs_t = ~hs_t; cyc(HB + x + 31, VB + y + 31, 1'b1, hs_t, 1'b1);
    if (x > 0)        begin hs_t = ~hs_t; cyc(HB + x - 1, VB + y, 1'b1, hs_t, 1'b1); end
    if (x + 32 < 640) begin hs_t = ~hs_t; cyc(HB + x + 32, VB + y, 1'b1, hs_t, 1'b1); end
    if (y > 0)        begin hs_t = ~hs_t; cyc(HB + x, VB + y - 1, 1'b1, hs_t, 1'b1); end
    if (y + 32 < 480) begin hs_t = ~hs_t; cyc(HB + x, VB + y + 32, 1'b1, hs_t, 1'b1); end
  endtask

  task automatic frame_tick();
    cyc(0, 0, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    probe(0);
    probe(1);
  endtask

  initial begin
    hs_t = 1'b1;
    model_reset();
    do_reset();
    cyc(HB + 304, VB + 224, 1'b1, 1'b1, 1'b1);
    probe(0);
    probe(1);

    run = 1'b1;
    for (int t = 0; t < 3; t++) frame_tick();

    run = 1'b0;
    for (int t = 0; t < 5; t++) frame_tick();

    run = 1'b1;
    for (int t = 0; t < 85; t++) frame_tick();

    // blanking inside the box
    cyc(HB + mx[0] + 2, VB + my[0] + 2, 1'b0, 1'b0, 1'b1);
    cyc(HB + mx[1] + 2, VB + my[1] + 2, 1'b0, 1'b1, 1'b1);

    // mid-frame reset with syncs low and box on screen
    cyc(HB + mx[0], VB + my[0], 1'b1, 1'b0, 1'b0);
    do_reset();
    cyc(HB + 304, VB + 224, 1'b1, 1'b1, 1'b1);
    frame_tick();

    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    pop_compare();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
